// File: rtl/rf_port_sched.sv
// rf_port_sched: shares one 1W/1R register file (flopped read data) among
// REQ_N requesters. Writes and reads are arbitrated independently with
// round-robin priority. Read results return tagged with the requester id
// over a valid/ready channel. A write to the address being read in the same
// cycle is forwarded through a bypass register.
module rf_port_sched #(
    parameter  int W     = 32,
    parameter  int N     = 8,
    parameter  int REQ_N = 4,
    localparam int AW    = $clog2(N),
    localparam int IW    = $clog2(REQ_N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REQ_N-1:0]             wr_req_vld,
    input  logic [REQ_N-1:0][AW-1:0]     wr_req_addr,
    input  logic [REQ_N-1:0][W-1:0]      wr_req_data,
    output logic [REQ_N-1:0]             wr_req_rdy,
    input  logic [REQ_N-1:0]             rd_req_vld,
    input  logic [REQ_N-1:0][AW-1:0]     rd_req_addr,
    output logic [REQ_N-1:0]             rd_req_rdy,
    output logic                         rsp_vld,
    output logic [IW-1:0]                rsp_id,
    output logic [W-1:0]                 rsp_data,
    input  logic                         rsp_rdy,
    output logic [AW-1:0]                rf_wa,
    output logic                         rf_wen,
    output logic [W-1:0]                 rf_wdata,
    output logic [AW-1:0]                rf_ra,
    output logic                         rf_ren,
    input  logic [W-1:0]                 rf_rdata
);

    // Round-robin search from ptr upward (mod REQ_N); returns {hit, index}.
    function automatic logic [IW:0] rr_pick(input logic [REQ_N-1:0] vld,
                                            input logic [IW-1:0]    ptr);
        logic [IW:0] res;
        int          c;
        res = '0;
        for (int k = 0; k < REQ_N; k++) begin
            c = (int'(ptr) + k) % REQ_N;
            if (!res[IW] && vld[c]) begin
                res = {1'b1, IW'(c)};
            end
        end
        return res;
    endfunction

    // Priority moves to the requester after the winner, wrapping at REQ_N-1.
    function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] idx);
        return (idx == IW'(REQ_N - 1)) ? '0 : idx + IW'(1);
    endfunction

    logic [IW-1:0] r_wr_ptr;
    logic [IW-1:0] r_rd_ptr;
    logic          r_rsp_vld;
    logic [IW-1:0] r_rsp_id;
    logic          r_byp_flg;
    logic [W-1:0]  r_byp_data;

    logic [IW:0]   w_wr_pick;
    logic [IW:0]   w_rd_pick;
    logic          w_wr_hit;
    logic          w_rd_hit;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;
    logic          w_slot_free;
    logic          w_byp_hit;

    assign w_wr_pick   = rr_pick(wr_req_vld, r_wr_ptr);
    assign w_wr_hit    = w_wr_pick[IW];
    assign w_wr_idx    = w_wr_pick[IW-1:0];

    // A read may issue only if the response slot is empty or draining now.
    assign w_slot_free = !r_rsp_vld || rsp_rdy;
    assign w_rd_pick   = rr_pick(rd_req_vld, r_rd_ptr);
    assign w_rd_hit    = w_rd_pick[IW] && w_slot_free;
    assign w_rd_idx    = w_rd_pick[IW-1:0];

    assign rf_wen      = w_wr_hit;
    assign rf_wa       = wr_req_addr[w_wr_idx];
    assign rf_wdata    = wr_req_data[w_wr_idx];
    assign rf_ren      = w_rd_hit;
    assign rf_ra       = rd_req_addr[w_rd_idx];

    // The array returns the pre-write value on a same-cycle collision.
    assign w_byp_hit   = w_rd_hit && w_wr_hit && (rf_ra == rf_wa);

    // One-hot grant vectors for the two arbiters.
    always_comb begin
        wr_req_rdy = '0;
        rd_req_rdy = '0;
        if (w_wr_hit) wr_req_rdy[w_wr_idx] = 1'b1;
        if (w_rd_hit) rd_req_rdy[w_rd_idx] = 1'b1;
    end

    // Round-robin pointers advance past each winner, hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_hit) r_wr_ptr <= ptr_next(w_wr_idx);
            if (w_rd_hit) r_rd_ptr <= ptr_next(w_rd_idx);
        end
    end

    // Response slot: load on issue, clear on accept without refill, else hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_vld <= 1'b0;
            r_rsp_id  <= '0;
            r_byp_flg <= 1'b0;
        end else if (w_rd_hit) begin
            r_rsp_vld <= 1'b1;
            r_rsp_id  <= w_rd_idx;
            r_byp_flg <= w_byp_hit;
        end else if (rsp_rdy) begin
            r_rsp_vld <= 1'b0;
        end
    end

    // Bypass data capture; only meaningful while r_byp_flg is set.
    always_ff @(posedge clk) begin
        if (w_byp_hit) r_byp_data <= rf_wdata;
    end

    assign rsp_vld  = r_rsp_vld;
    assign rsp_id   = r_rsp_id;
    assign rsp_data = r_byp_flg ? r_byp_data : rf_rdata;

endmodule

// File: tb/tb_rf_port_sched.sv
// Directed bench for rf_port_sched with a behavioural 1W/1R register file
// (flopped read, returns the pre-write value on a same-edge collision).
module tb_rf_port_sched;

    localparam logic [31:0] A0 = 32'hA000_0000;
    localparam logic [31:0] A1 = 32'hA111_1111;
    localparam logic [31:0] A2 = 32'hA222_2222;
    localparam logic [31:0] A3 = 32'hA333_3333;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [3:0]        wr_req_vld = '0;
    logic [3:0][2:0]   wr_req_addr = '0;
    logic [3:0][31:0]  wr_req_data = '0;
    logic [3:0]        wr_req_rdy;
    logic [3:0]        rd_req_vld = '0;
    logic [3:0][2:0]   rd_req_addr = '0;
    logic [3:0]        rd_req_rdy;
    logic              rsp_vld;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_data;
    logic              rsp_rdy = 1'b1;
    logic [2:0]        rf_wa;
    logic              rf_wen;
    logic [31:0]       rf_wdata;
    logic [2:0]        rf_ra;
    logic              rf_ren;
    logic [31:0]       rf_rdata;
    logic [31:0]       mem [8];

    int n_asrt = 0;
    int n_fail = 0;

    rf_port_sched #(.W(32), .N(8), .REQ_N(4)) dut (
        .clk(clk), .rst(rst),
        .wr_req_vld(wr_req_vld), .wr_req_addr(wr_req_addr),
        .wr_req_data(wr_req_data), .wr_req_rdy(wr_req_rdy),
        .rd_req_vld(rd_req_vld), .rd_req_addr(rd_req_addr),
        .rd_req_rdy(rd_req_rdy),
        .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_rdy(rsp_rdy),
        .rf_wa(rf_wa), .rf_wen(rf_wen), .rf_wdata(rf_wdata),
        .rf_ra(rf_ra), .rf_ren(rf_ren), .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    // Register file model.
    always @(posedge clk) begin
        if (rf_wen) mem[rf_wa] <= rf_wdata;
        if (rf_ren) rf_rdata <= mem[rf_ra];
    end

    typedef struct packed {
        logic [3:0]   wv;
        logic [11:0]  wa;
        logic [127:0] wd;
        logic [3:0]   rv;
        logic [11:0]  ra;
        logic         rdy;
        logic [3:0]   ewr;
        logic [3:0]   err;
        logic [2:0]   ewa;
        logic [31:0]  ewd;
        logic [2:0]   era;
        logic         ev;
        logic [1:0]   eid;
        logic [31:0]  edata;
    } vec_t;

    function automatic vec_t mk(
        input logic [3:0] wv, input logic [11:0] wa, input logic [127:0] wd,
        input logic [3:0] rv, input logic [11:0] ra, input logic rdy,
        input logic [3:0] ewr, input logic [3:0] err, input logic [2:0] ewa,
        input logic [31:0] ewd, input logic [2:0] era,
        input logic ev, input logic [1:0] eid, input logic [31:0] edata);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.rdy = rdy;
        v.ewr = ewr; v.err = err; v.ewa = ewa; v.ewd = ewd; v.era = era;
        v.ev = ev; v.eid = eid; v.edata = edata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] wv, input logic [11:0] wa, input logic [127:0] wd,
                         input logic [3:0] rv, input logic [11:0] ra, input logic rdy);
        @(negedge clk);
        wr_req_vld  = wv;
        wr_req_addr = wa;
        wr_req_data = wd;
        rd_req_vld  = rv;
        rd_req_addr = ra;
        rsp_rdy     = rdy;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t          tbl [13];
        logic [31:0]   av [4];
        logic [11:0]   wa_all;
        logic [127:0]  wd_all;
        av     = '{A0, A1, A2, A3};
        wa_all = {3'd3, 3'd2, 3'd1, 3'd0};
        wd_all = {A3, A2, A1, A0};

        //            wv      wa        wd                                 rv      ra       rdy ewr     err     ewa   ewd            era   ev  eid   edata
        tbl[0]  = mk(4'h0,  12'h000,  '0,                                4'h0,   12'h000, 1, 4'h0,   4'h0,   3'd0, 32'h0,         3'd0, 0, 2'd0, 32'h0);
        tbl[1]  = mk(4'hF,  wa_all,   wd_all,                            4'h0,   12'h000, 1, 4'b0001,4'h0,   3'd0, A0,            3'd0, 0, 2'd0, 32'h0);
        tbl[2]  = mk(4'hF,  wa_all,   wd_all,                            4'h0,   12'h000, 1, 4'b0010,4'h0,   3'd1, A1,            3'd0, 0, 2'd0, 32'h0);
        tbl[3]  = mk(4'hF,  wa_all,   wd_all,                            4'h0,   12'h000, 1, 4'b0100,4'h0,   3'd2, A2,            3'd0, 0, 2'd0, 32'h0);
        tbl[4]  = mk(4'hF,  wa_all,   wd_all,                            4'h0,   12'h000, 1, 4'b1000,4'h0,   3'd3, A3,            3'd0, 0, 2'd0, 32'h0);
        tbl[5]  = mk(4'h0,  12'h000,  '0,                                4'b0100,12'h040, 1, 4'h0,   4'b0100,3'd0, 32'h0,         3'd1, 0, 2'd0, 32'h0);
        tbl[6]  = mk(4'b0010,12'h028, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}, 4'b1000,12'hA00, 1, 4'b0010,4'b1000,3'd5, 32'hDEADBEEF, 3'd5, 1, 2'd2, A1);
        tbl[7]  = mk(4'h0,  12'h000,  '0,                                4'h0,   12'h000, 1, 4'h0,   4'h0,   3'd0, 32'h0,         3'd0, 1, 2'd3, 32'hDEADBEEF);
        tbl[8]  = mk(4'b0101,12'h187, {32'h0, 32'h2222_0006, 32'h0, 32'h1111_0007}, 4'h0, 12'h000, 1, 4'b0100,4'h0, 3'd6, 32'h2222_0006, 3'd0, 0, 2'd0, 32'h0);
        tbl[9]  = mk(4'b0101,12'h187, {32'h0, 32'h2222_0006, 32'h0, 32'h1111_0007}, 4'h0, 12'h000, 1, 4'b0001,4'h0, 3'd7, 32'h1111_0007, 3'd0, 0, 2'd0, 32'h0);
        tbl[10] = mk(4'h0,  12'h000,  '0,                                4'b0001,12'h006, 1, 4'h0,   4'b0001,3'd0, 32'h0,         3'd6, 0, 2'd0, 32'h0);
        tbl[11] = mk(4'h0,  12'h000,  '0,                                4'h0,   12'h000, 1, 4'h0,   4'h0,   3'd0, 32'h0,         3'd0, 1, 2'd0, 32'h2222_0006);
        tbl[12] = mk(4'h0,  12'h000,  '0,                                4'h0,   12'h000, 1, 4'h0,   4'h0,   3'd0, 32'h0,         3'd0, 0, 2'd0, 32'h0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset rsp_vld", 32'(rsp_vld), 32'd0);
        chk("reset rsp_id", 32'(rsp_id), 32'd0);
        chk("reset wr_rdy", 32'(wr_req_rdy), 32'd0);
        chk("reset rd_rdy", 32'(rd_req_rdy), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table: write round-robin, read latency, bypass, pointer wrap
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra, tbl[i].rdy);
            chk($sformatf("v%0d wr_rdy", i), 32'(wr_req_rdy), 32'(tbl[i].ewr));
            chk($sformatf("v%0d rd_rdy", i), 32'(rd_req_rdy), 32'(tbl[i].err));
            chk($sformatf("v%0d rf_wen", i), 32'(rf_wen), 32'(|tbl[i].ewr));
            chk($sformatf("v%0d rf_ren", i), 32'(rf_ren), 32'(|tbl[i].err));
            chk($sformatf("v%0d rsp_vld", i), 32'(rsp_vld), 32'(tbl[i].ev));
            if (|tbl[i].ewr) begin
                chk($sformatf("v%0d rf_wa", i), 32'(rf_wa), 32'(tbl[i].ewa));
                chk($sformatf("v%0d rf_wdata", i), rf_wdata, tbl[i].ewd);
            end
            if (|tbl[i].err) chk($sformatf("v%0d rf_ra", i), 32'(rf_ra), 32'(tbl[i].era));
            if (tbl[i].ev) begin
                chk($sformatf("v%0d rsp_id", i), 32'(rsp_id), 32'(tbl[i].eid));
                chk($sformatf("v%0d rsp_data", i), rsp_data, tbl[i].edata);
            end
        end

        // Backpressure: requesters 0,1 read addr 0,1; rd_ptr is 1 here
        drive('0, '0, '0, 4'b0011, 12'h008, 1'b0);
        chk("bp0 rd_rdy", 32'(rd_req_rdy), 32'b0010);
        chk("bp0 rf_ra", 32'(rf_ra), 32'd1);
        chk("bp0 rsp_vld", 32'(rsp_vld), 32'd0);
        for (int s = 1; s <= 3; s++) begin
            drive('0, '0, '0, 4'b0011, 12'h008, 1'b0);
            chk($sformatf("bp%0d rd_rdy", s), 32'(rd_req_rdy), 32'd0);
            chk($sformatf("bp%0d rf_ren", s), 32'(rf_ren), 32'd0);
            chk($sformatf("bp%0d rsp_vld", s), 32'(rsp_vld), 32'd1);
            chk($sformatf("bp%0d rsp_id", s), 32'(rsp_id), 32'd1);
            chk($sformatf("bp%0d rsp_data", s), rsp_data, A1);
        end
        drive('0, '0, '0, 4'b0011, 12'h008, 1'b1);
        chk("bp4 rd_rdy", 32'(rd_req_rdy), 32'b0001);
        chk("bp4 rf_ren", 32'(rf_ren), 32'd1);
        chk("bp4 rf_ra", 32'(rf_ra), 32'd0);
        chk("bp4 rsp_id", 32'(rsp_id), 32'd1);
        drive('0, '0, '0, 4'b0000, 12'h000, 1'b1);
        chk("bp5 rsp_vld", 32'(rsp_vld), 32'd1);
        chk("bp5 rsp_id", 32'(rsp_id), 32'd0);
        chk("bp5 rsp_data", rsp_data, A0);
        drive('0, '0, '0, 4'b0000, 12'h000, 1'b1);
        chk("bp6 rsp_vld", 32'(rsp_vld), 32'd0);

        // Mid-operation reset right after a read issues
        drive('0, '0, '0, 4'b0010, 12'h010, 1'b1);
        chk("mr issue rd_rdy", 32'(rd_req_rdy), 32'b0010);
        drive('0, '0, '0, 4'b0000, 12'h000, 1'b1);
        chk("mr pre rsp_vld", 32'(rsp_vld), 32'd1);
        rst = 1'b0;
        #1;
        chk("mr async rsp_vld", 32'(rsp_vld), 32'd0);
        chk("mr async rsp_id", 32'(rsp_id), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mr rel rsp_vld", 32'(rsp_vld), 32'd0);
        drive('0, '0, '0, 4'b0000, 12'h000, 1'b1);
        chk("mr post rsp_vld", 32'(rsp_vld), 32'd0);

        // Fairness: everyone writes and reads its own address for 12 cycles
        for (int k = 0; k < 12; k++) begin
            drive(4'hF, wa_all, wd_all, 4'hF, wa_all, 1'b1);
            chk($sformatf("fair%0d wr_rdy", k), 32'(wr_req_rdy), 32'(1 << (k % 4)));
            chk($sformatf("fair%0d rd_rdy", k), 32'(rd_req_rdy), 32'(1 << (k % 4)));
            chk($sformatf("fair%0d rf_ra", k), 32'(rf_ra), 32'(k % 4));
            if (k == 0) begin
                chk("fair0 rsp_vld", 32'(rsp_vld), 32'd0);
            end else begin
                chk($sformatf("fair%0d rsp_vld", k), 32'(rsp_vld), 32'd1);
                chk($sformatf("fair%0d rsp_id", k), 32'(rsp_id), 32'((k - 1) % 4));
                chk($sformatf("fair%0d rsp_data", k), rsp_data, av[(k - 1) % 4]);
            end
        end
        drive('0, '0, '0, 4'b0000, 12'h000, 1'b1);
        chk("fair end rsp_id", 32'(rsp_id), 32'd3);
        chk("fair end rsp_data", rsp_data, A3);
        drive('0, '0, '0, 4'b0000, 12'h000, 1'b1);
        chk("fair drain rsp_vld", 32'(rsp_vld), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_port_sched.md
Name: rf_port_sched

Overview:
- Shares one register file, configured with one write port, one read port and flopped output, among REQ_N requesters.
- Arbitrates write and read requests independently with round-robin priority.
- Drives the register file's address, enable and data pins.
- Returns each read result tagged with its requester id over a valid/ready response channel, with same-cycle write-to-read bypass.

Parameters:
- W, 32, data width; must equal the register file's W.
- N, 8, register file entries; address width AW = $clog2(N).
- REQ_N, 4, number of requesters; legal range 2..16; id width IW = $clog2(REQ_N).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- wr_req_vld  in  REQ_N  per-requester write request.
- wr_req_addr  in  REQ_N x AW  write address.
- wr_req_data  in  REQ_N x W  write data.
- wr_req_rdy  out  REQ_N  write grant; one-hot or zero.
- rd_req_vld  in  REQ_N  per-requester read request.
- rd_req_addr  in  REQ_N x AW  read address.
- rd_req_rdy  out  REQ_N  read grant; one-hot or zero.
- rsp_vld  out  1  read response valid.
- rsp_id  out  IW  requester index of the response.
- rsp_data  out  W  read data.
- rsp_rdy  in  1  response accepted.
- rf_wa  out  AW  register file write address.
- rf_wen  out  1  register file write enable.
- rf_wdata  out  W  register file write data.
- rf_ra  out  AW  register file read address.
- rf_ren  out  1  register file read enable.
- rf_rdata  in  W  register file flopped read data, valid 1 cycle after rf_ren.

Behaviour:
- Reset (rst=0, async):
  - rsp_vld=0, rsp_id=0, bypass flag=0.
  - Write and read priority pointers = 0.
  - All *_rdy outputs are combinational and therefore 0 while no request is valid.
  - An in-flight response is discarded; no response appears after reset release.
- Write arbitration, every cycle:
  - Search wr_req_vld from wr_ptr upward, modulo REQ_N.
  - First set bit i wins: wr_req_rdy[i]=1; rf_wen=1, rf_wa=wr_req_addr[i], rf_wdata=wr_req_data[i].
  - wr_ptr <= (i+1) mod REQ_N on grant; unchanged when idle.
  - Write accepted in 0 cycles; the write lands in the array at the same clock edge.
  - A write is never stalled by read activity.
- Read issue condition: slot_free = !rsp_vld | rsp_rdy.
- Read arbitration:
  - Active only when slot_free. Same round-robin scheme using rd_ptr.
  - Winner j: rd_req_rdy[j]=1, rf_ren=1, rf_ra=rd_req_addr[j].
  - rd_ptr <= (j+1) mod REQ_N.
  - When !slot_free: all rd_req_rdy=0, rf_ren=0, rd_ptr unchanged.
- Response timing:
  - Issue in cycle T gives rsp_vld=1 and rsp_id=j in cycle T+1.
  - Read-to-response latency is exactly 1 cycle.
  - Back-to-back issue gives 1 response per cycle while rsp_rdy=1.
- Response hold:
  - While rsp_vld & !rsp_rdy, rsp_id and rsp_data hold stable.
  - rf_ren=0 keeps rf_rdata frozen; the bypass register holds.
- Drain: rsp_vld clears on rsp_vld & rsp_rdy with no new issue that cycle.
- Bypass:
  - Applies when a read and a write issue in the same cycle with rf_ra==rf_wa.
  - Capture rf_wdata into a bypass register and set the bypass flag.
  - rsp_data = flag ? bypass register : rf_rdata.
  - Net effect: a read observes any write granted in the same or an earlier cycle.
- Same requester may read and write in one cycle; both are arbitrated independently.
- Pointer wrap: pointer at REQ_N-1 with a grant to REQ_N-1 wraps to 0.
- A requester whose vld drops before grant is not granted and is not remembered.
- Starvation bound: a continuously asserting requester is granted within REQ_N grant cycles.

Test Plan:
- Reset then write: requesters 0..3 all assert write, addrs 0..3, data A0..A3 → grants 0,1,2,3 over 4 cycles, one per cycle; rf_wen=1 each cycle; wr_ptr ends at 0.
- Read latency: after the writes, requester 2 reads addr 1 → rd_req_rdy[2] same cycle; next cycle rsp_vld=1, rsp_id=2, rsp_data=A1.
- Bypass: requester 1 writes addr 5 = 0xDEADBEEF while requester 3 reads addr 5 in the same cycle → next cycle rsp_data=0xDEADBEEF, rsp_id=3.
- Backpressure: rsp_rdy=0 for 3 cycles with requesters 0 and 1 reading →
  - rd_req_rdy=0 and rf_ren=0 while stalled;
  - rsp_id and rsp_data stable;
  - on rsp_rdy=1, the next read issues the same cycle and its response follows 1 cycle later.
- Fairness: all REQ_N requesters hold reads for 12 cycles with rsp_rdy=1 → grant sequence 0,1,2,3,0,1,2,3,…; no requester waits more than 4 cycles.
- Mid-operation reset: assert rst low in the cycle after a read issues → rsp_vld=0 immediately; after release, no stale response appears and both pointers restart at 0.
